// File: rtl/instruction_fetch_queue.sv
// Fetch stage: reads opcode/operand pairs from a dual-port blockram and queues
// them with their PC for the out-of-order core; halts on process end, restarts on redirect.
module instruction_fetch_queue #(
    parameter int          DEPTH      = 8,
    parameter logic [15:0] START_PC   = 16'd50,
    parameter logic [7:0]  END_OPCODE = 8'h18
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [15:0]                read_address,
    input  logic [15:0]                read_value,
    output logic [15:0]                read_address2,
    input  logic [15:0]                read_value2,
    input  logic                       redirect_valid,
    input  logic [15:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_pc,
    output logic [15:0]                out_opcode,
    output logic [15:0]                out_operand,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       halted
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_HALT  = 1'b1;

    logic [15:0]   r_pc;
    logic [0:0]    r_state;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_mem_pc      [DEPTH];
    logic [15:0]   r_mem_opcode  [DEPTH];
    logic [15:0]   r_mem_operand [DEPTH];

    logic w_push;
    logic w_pop;
    logic w_is_end;

    // Push decision uses only the registered count, so a same-cycle pop never frees a slot.
    assign w_push   = (r_state == S_FETCH) && (r_count < CW'(DEPTH)) && !redirect_valid;
    assign w_pop    = out_valid && out_ready && !redirect_valid;
    assign w_is_end = (read_value[15:8] == END_OPCODE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= START_PC;
            r_state  <= S_FETCH;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]      <= '0;
                r_mem_opcode[i]  <= '0;
                r_mem_operand[i] <= '0;
            end
        end else if (redirect_valid) begin
            // Queued entries are abandoned in place; only the pointers and count reset.
            r_pc     <= redirect_pc;
            r_state  <= S_FETCH;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_pc[r_wr_ptr]      <= r_pc;
                r_mem_opcode[r_wr_ptr]  <= read_value;
                r_mem_operand[r_wr_ptr] <= read_value2;
                r_wr_ptr                <= r_wr_ptr + PW'(1);
                r_pc                    <= r_pc + 16'd2;
                if (w_is_end) begin
                    r_state <= S_HALT;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign read_address  = r_pc;
    assign read_address2 = r_pc + 16'd1;
    assign out_valid     = (r_count != '0);
    assign out_pc        = r_mem_pc[r_rd_ptr];
    assign out_opcode    = r_mem_opcode[r_rd_ptr];
    assign out_operand   = r_mem_operand[r_rd_ptr];
    assign count         = r_count;
    assign halted        = (r_state == S_HALT);

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the fetch behaviour.
module tb_instruction_fetch_queue;

    localparam int          DEPTH    = 8;
    localparam logic [15:0] START_PC = 16'd50;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] read_address, read_value, read_address2, read_value2;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [15:0] out_pc, out_opcode, out_operand;
    logic [3:0]  count;
    logic        halted;

    logic [15:0] mem [0:65535];

    int vectors = 0;
    int errs    = 0;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] op;
        logic [15:0] opnd;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_pc;
    bit          m_halt;
    bit          m_fresh;
    bit          m_known = 1'b0;

    always #5 clk = ~clk;

    assign read_value  = mem[read_address];
    assign read_value2 = mem[read_address2];

    instruction_fetch_queue #(
        .DEPTH(DEPTH), .START_PC(START_PC), .END_OPCODE(8'h18)
    ) dut (
        .clk(clk), .rst(rst),
        .read_address(read_address), .read_value(read_value),
        .read_address2(read_address2), .read_value2(read_value2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode), .out_operand(out_operand),
        .count(count), .halted(halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        logic [15:0] a2;
        if (!m_known) return;
        a2 = m_pc + 16'd1;
        chk("count", 32'(count), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("read_address", 32'(read_address), 32'(m_pc));
        chk("read_address2", 32'(read_address2), 32'(a2));
        if (q.size() != 0) begin
            chk("out_pc", 32'(out_pc), 32'(q[0].pc));
            chk("out_opcode", 32'(out_opcode), 32'(q[0].op));
            chk("out_operand", 32'(out_operand), 32'(q[0].opnd));
        end else if (m_fresh) begin
            chk("out_zero", {out_pc, out_opcode | out_operand}, 32'h0);
        end
    endtask

    task automatic model_step(input bit r, input bit rv, input logic [15:0] rpc, input bit rdy);
        bit   push, pop;
        ent_t e;
        logic [15:0] a2;
        if (r) begin
            q.delete();
            m_pc    = START_PC;
            m_halt  = 1'b0;
            m_fresh = 1'b1;
            m_known = 1'b1;
        end else if (!m_known) begin
            return;
        end else if (rv) begin
            q.delete();
            m_pc   = rpc;
            m_halt = 1'b0;
        end else begin
            push = !m_halt && (q.size() < DEPTH);
            pop  = (q.size() != 0) && rdy;
            if (pop) void'(q.pop_front());
            if (push) begin
                a2     = m_pc + 16'd1;
                e.pc   = m_pc;
                e.op   = mem[m_pc];
                e.opnd = mem[a2];
                q.push_back(e);
                m_fresh = 1'b0;
                if (e.op[15:8] == 8'h18) m_halt = 1'b1;
                m_pc = m_pc + 16'd2;
            end
        end
    endtask

    // One clock: drive inputs, check against the model, advance both at the edge.
    task automatic cycle(input bit r, input bit rv, input logic [15:0] rpc, input bit rdy);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        model_check();
        @(posedge clk);
        model_step(r, rv, rpc, rdy);
        #1;
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, rdy);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a] = 16'($urandom);
            if (mem[a][15:8] == 8'h18) mem[a][15:8] = 8'h19;
        end
        mem[50] = 16'h1210; mem[51] = 16'h0A35;
        mem[52] = 16'h0E10; mem[53] = 16'd290;
        mem[54] = 16'h0911; mem[55] = 16'd100;

        // Reset and streaming from START_PC
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", 32'(out_pc), 32'd0);
        chk("rst_raddr", 32'(read_address), 32'd50);
        chk("rst_raddr2", 32'(read_address2), 32'd51);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        chk("s0_pc", 32'(out_pc), 32'd50);
        chk("s0_op", 32'(out_opcode), 32'h1210);
        chk("s0_opnd", 32'(out_operand), 32'h0A35);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        chk("s1_pc", 32'(out_pc), 32'd52);
        chk("s1_opnd", 32'(out_operand), 32'd290);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        chk("s2_pc", 32'(out_pc), 32'd54);
        chk("s2_op", 32'(out_opcode), 32'h0911);
        run(4, 1'b1);

        // Fill with no consumer, then drain
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        run(9, 1'b0);
        chk("full_count", 32'(count), 32'd8);
        chk("full_raddr", 32'(read_address), 32'd66);
        run(12, 1'b1);

        // Reset pulse while full
        run(9, 1'b0);
        chk("full2_count", 32'(count), 32'd8);
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        chk("rstfull_count", 32'(count), 32'd0);
        chk("rstfull_valid", 32'(out_valid), 32'd0);
        chk("rstfull_op", 32'(out_opcode), 32'd0);
        chk("rstfull_raddr", 32'(read_address), 32'd50);

        // Process end at pc 64
        mem[64] = 16'h1800; mem[65] = 16'h0007;
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        run(9, 1'b0);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_count", 32'(count), 32'd8);
        chk("halt_raddr", 32'(read_address), 32'd66);
        run(7, 1'b1);
        chk("halt_last_op", 32'(out_opcode), 32'h1800);
        chk("halt_last_opnd", 32'(out_operand), 32'h0007);
        run(3, 1'b1);
        chk("halt_empty", 32'(out_valid), 32'd0);

        // Redirect while halted, then while streaming
        cycle(1'b0, 1'b1, 16'd250, 1'b1);
        chk("rd_count", 32'(count), 32'd0);
        chk("rd_halted", 32'(halted), 32'd0);
        chk("rd_raddr", 32'(read_address), 32'd250);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        chk("rd_pc", 32'(out_pc), 32'd250);
        run(3, 1'b1);
        cycle(1'b0, 1'b1, 16'd250, 1'b1);
        run(3, 1'b0);

        // Address wrap
        cycle(1'b0, 1'b1, 16'hFFFE, 1'b1);
        chk("wrap_raddr", 32'(read_address), 32'hFFFE);
        chk("wrap_raddr2", 32'(read_address2), 32'hFFFF);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        chk("wrap_pc0", 32'(out_pc), 32'hFFFE);
        chk("wrap_next", 32'(read_address), 32'h0000);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        chk("wrap_pc1", 32'(out_pc), 32'h0000);

        // Random traffic with sprinkled process ends
        for (int i = 0; i < 200; i++) mem[16'($urandom)][15:8] = 8'h18;
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(99) == 0), ($urandom_range(19) == 0),
                  ($urandom_range(3) == 0) ? 16'hFFFC + 16'($urandom_range(3)) : 16'($urandom),
                  ($urandom_range(9) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
